dmem_access_ctrl: RTL

- Multi-cycle sequencer between the single-cycle core datapath and a handshaked data memory.
- Accepts load/store requests from the instruction controller (read/write enables, func3, ALU address, rs2 data).
- Drives a req/ack memory port and stalls PC and register-file writeback until the access completes.
- Performs byte-lane steering for stores and lane extraction with sign/zero extension for loads.

---
 rtl/dmem_access_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer between the core datapath and a req/ack data memory.
// Optional DMEM_MISALIGN_CHK_EN: misaligned half/word accesses finish with err=1 and no mem_req.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dmem_read_en,
    input  logic                  dmem_write_en,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [2:0]            func3_q, func3_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  err_q, err_d;

    logic                  access_c, is_store_c, stall_c;
    logic [CntW-1:0]       cnt_inc_c;
    logic [3:0]            strb_c;
    logic [DATA_WIDTH-1:0] wdata_c, ext_c;
    logic [7:0]            byte_c;
    logic [15:0]           half_c;

    assign access_c   = dmem_read_en | dmem_write_en;
    assign is_store_c = ~dmem_read_en & dmem_write_en;
    assign cnt_inc_c  = cnt_q + 1'b1;

`ifdef DMEM_MISALIGN_CHK_EN
    logic half_op_c, misalign_c;
    // Store func3 101 is not sh, so only loads treat both 001 and 101 as halfword.
    assign half_op_c  = is_store_c ? (func3 == 3'b001) : (func3[1:0] == 2'b01);
    assign misalign_c = (half_op_c & addr[0]) | ((func3 == 3'b010) & (addr[1:0] != 2'b00));
`endif

    always_comb begin
        strb_c  = 4'hF;
        wdata_c = store_data;
        case (func3)
            3'b000: begin
                strb_c  = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            3'b001: begin
                strb_c  = 4'b0011 << {addr[1], 1'b0};
                wdata_c = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_c = mem_rdata[{off_q, 3'b000} +: 8];
        half_c = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (func3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  ext_c = {24'h0, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b101:  ext_c = {16'h0, half_c};
            default: ext_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        func3_d     = func3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        stall_c     = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_c = access_c;
                if (access_c) begin
                    mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_we_d    = is_store_c;
                    mem_wstrb_d = is_store_c ? strb_c : 4'h0;
                    mem_wdata_d = is_store_c ? wdata_c : '0;
                    func3_d     = func3;
                    off_d       = addr[1:0];
`ifdef DMEM_MISALIGN_CHK_EN
                    if (misalign_c) begin
                        state_d     = StDone;
                        err_d       = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d = StReq;
                    end
`else
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                stall_c = 1'b1;
                cnt_d   = cnt_inc_c;
                if (mem_ack) begin
                    state_d     = StDone;
                    err_d       = 1'b0;
                    load_data_d = ext_c;
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc_c == TimeoutVal) begin
                    state_d     = StDone;
                    err_d       = 1'b1;
                    load_data_d = '0;
                end
            end
            StDone: begin
                // Always back to IDLE; a still-asserted enable must not relaunch the access.
                state_d     = StIdle;
                cnt_d       = '0;
                err_d       = 1'b0;
                load_data_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'h0;
            func3_q     <= 3'b000;
            off_q       <= 2'b00;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    assign stall     = stall_c & rst_n;
    assign done      = (state_q == StDone);
    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign load_data = load_data_q;
    assign err       = err_q;

endmodule
